// File: rtl/dtcm_lsu_ctrl_if.sv
// AGU command/response and long-pipe write-back bundle between the EXU and
// the DTCM load/store controller. The EXU side is the master.
interface dtcm_lsu_ctrl_if #(
  parameter int XLEN        = 32,
  parameter int DTCM_RAM_AW = 16,
  parameter int ITAG_WIDTH  = 1
);
  // AGU command channel
  logic                   agu_cmd_valid;
  logic                   agu_cmd_ready;
  logic [DTCM_RAM_AW-1:0] agu_cmd_addr;
  logic                   agu_cmd_read;
  logic [ITAG_WIDTH-1:0]  agu_cmd_itag;
  logic [XLEN-1:0]        agu_cmd_wdata;
  logic [XLEN/8-1:0]      agu_cmd_wmask;

  // AGU response channel (store completions)
  logic                   agu_rsp_valid;
  logic                   agu_rsp_ready;
  logic [XLEN-1:0]        agu_rsp_rdata;

  // Long-pipe write-back channel (load data)
  logic                   lsu_wbck_o_valid;
  logic                   lsu_wbck_o_ready;
  logic [XLEN-1:0]        lsu_wbck_o_data;
  logic [ITAG_WIDTH-1:0]  lsu_wbck_o_itag;

  modport master (
    output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_itag,
           agu_cmd_wdata, agu_cmd_wmask, agu_rsp_ready, lsu_wbck_o_ready,
    input  agu_cmd_ready, agu_rsp_valid, agu_rsp_rdata,
           lsu_wbck_o_valid, lsu_wbck_o_data, lsu_wbck_o_itag
  );

  modport slave (
    input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_itag,
           agu_cmd_wdata, agu_cmd_wmask, agu_rsp_ready, lsu_wbck_o_ready,
    output agu_cmd_ready, agu_rsp_valid, agu_rsp_rdata,
           lsu_wbck_o_valid, lsu_wbck_o_data, lsu_wbck_o_itag
  );
endinterface

// File: rtl/dtcm_lsu_ctrl.sv
// DTCM load/store controller. Commands hit the single-port SRAM in the cycle
// they are accepted; results are captured one cycle later into an in-order
// response FIFO whose head is routed to either the load write-back port or
// the store completion port. A credit counter bounds outstanding commands so
// the FIFO never overflows and command ready never depends on output readys.
module dtcm_lsu_ctrl #(
  parameter int XLEN        = 32,
  parameter int DTCM_RAM_AW = 16,
  parameter int ITAG_WIDTH  = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dtcm_lsu_ctrl_if.slave         bus,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic [DTCM_RAM_AW-3:0] ram_addr,
  output logic [XLEN/8-1:0]      ram_wem,
  output logic [XLEN-1:0]        ram_din,
  input  logic [XLEN-1:0]        ram_dout,
  output logic                   lsu_idle
);
  localparam int PW = $clog2(RSP_DEPTH) + 1;  // pointer width incl. wrap bit
  localparam int IW = PW - 1;                 // storage index width
  localparam int CW = $clog2(RSP_DEPTH + 1);  // credit counter width

  logic                  acc;
  logic                  pop;
  logic                  s1_vld;
  logic                  s1_read;
  logic [ITAG_WIDTH-1:0] s1_itag;
  logic [XLEN-1:0]       push_data;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic                  head_vld;
  logic                  head_read;
  logic                  unused_addr_lsb;

  // Response storage: not reset, only the pointers qualify its contents.
  logic                  read_q [RSP_DEPTH];
  logic [ITAG_WIDTH-1:0] itag_q [RSP_DEPTH];
  logic [XLEN-1:0]       data_q [RSP_DEPTH];

  // Command side: accept while credits remain; RAM is driven straight from it.
  assign bus.agu_cmd_ready = (cnt < CW'(RSP_DEPTH));
  assign acc               = bus.agu_cmd_valid & bus.agu_cmd_ready;
  assign ram_cs            = acc;
  assign ram_we            = acc & ~bus.agu_cmd_read;
  assign ram_addr          = bus.agu_cmd_addr[DTCM_RAM_AW-1:2];
  assign ram_wem           = ram_we ? bus.agu_cmd_wmask : '0;
  assign ram_din           = bus.agu_cmd_wdata;
  assign unused_addr_lsb   = ^bus.agu_cmd_addr[1:0];

  // Stores complete with zero data; loads carry the word the RAM returns now.
  assign push_data = s1_read ? ram_dout : '0;

  // FIFO head routing: the head entry decides which output port it uses.
  assign wr_idx    = wr_ptr[IW-1:0];
  assign rd_idx    = rd_ptr[IW-1:0];
  assign head_vld  = (wr_ptr != rd_ptr);
  assign head_read = read_q[rd_idx];

  assign bus.lsu_wbck_o_valid = head_vld & head_read;
  assign bus.agu_rsp_valid    = head_vld & ~head_read;
  assign bus.lsu_wbck_o_data  = data_q[rd_idx];
  assign bus.lsu_wbck_o_itag  = itag_q[rd_idx];
  assign bus.agu_rsp_rdata    = data_q[rd_idx];

  assign pop = head_vld & (head_read ? bus.lsu_wbck_o_ready : bus.agu_rsp_ready);

  assign lsu_idle = (cnt == '0);

  // Stage 1 tracks the command whose RAM access is completing this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_read <= 1'b0;
      s1_itag <= '0;
    end else begin
      s1_vld  <= acc;
      s1_read <= bus.agu_cmd_read;
      s1_itag <= bus.agu_cmd_itag;
    end
  end

  // Credits: one per command from acceptance until its response pops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({acc, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO pointers advance on push (stage-1 valid) and on output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (s1_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Capture the stage-1 result into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (s1_vld) begin
      read_q[wr_idx] <= s1_read;
      itag_q[wr_idx] <= s1_itag;
      data_q[wr_idx] <= push_data;
    end
  end
endmodule

// File: tb/tb_dtcm_lsu_ctrl.sv
// Directed bench for dtcm_lsu_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_dtcm_lsu_ctrl;
  localparam int XLEN  = 32;
  localparam int AW    = 16;
  localparam int IW    = 1;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic              ram_cs;
  logic              ram_we;
  logic [AW-3:0]     ram_addr;
  logic [XLEN/8-1:0] ram_wem;
  logic [XLEN-1:0]   ram_din;
  logic [XLEN-1:0]   ram_dout;
  logic              lsu_idle;

  dtcm_lsu_ctrl_if #(.XLEN(XLEN), .DTCM_RAM_AW(AW), .ITAG_WIDTH(IW)) bus ();

  dtcm_lsu_ctrl #(
    .XLEN(XLEN), .DTCM_RAM_AW(AW), .ITAG_WIDTH(IW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wem  (ram_wem),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .lsu_idle (lsu_idle)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM
  logic [31:0] mem [0:(1<<(AW-2))-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        itag;
    int          cyc;
  } resp_t;

  resp_t wb_q[$];
  resp_t rsp_q[$];
  int    acc_count = 0;

  // Record every handshake (inputs are stable at the falling edge)
  always @(negedge clk) begin
    if (bus.agu_cmd_valid && bus.agu_cmd_ready) acc_count++;
    if (bus.lsu_wbck_o_valid && bus.lsu_wbck_o_ready)
      wb_q.push_back('{data: bus.lsu_wbck_o_data, itag: bus.lsu_wbck_o_itag[0], cyc: cyc});
    if (bus.agu_rsp_valid && bus.agu_rsp_ready)
      rsp_q.push_back('{data: bus.agu_rsp_rdata, itag: 1'b0, cyc: cyc});
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted; returns the accept cycle.
  task automatic issue(input logic rd, input logic [15:0] addr, input logic it,
                       input logic [31:0] wd, input logic [3:0] wm, output int acc_cyc);
    bus.agu_cmd_valid = 1'b1;
    bus.agu_cmd_read  = rd;
    bus.agu_cmd_addr  = addr;
    bus.agu_cmd_itag  = it;
    bus.agu_cmd_wdata = wd;
    bus.agu_cmd_wmask = wm;
    acc_cyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.agu_cmd_ready) begin
        acc_cyc = cyc;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.agu_cmd_valid = 1'b0;
    if (acc_cyc < 0) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic pop_wb(input string tag, input logic [31:0] d, input logic it, input int ecyc);
    resp_t r;
    if (wb_q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      r = wb_q.pop_front();
      check({tag, "_data"}, 64'(r.data), 64'(d));
      check({tag, "_itag"}, 64'(r.itag), 64'(it));
      if (ecyc >= 0) check({tag, "_cyc"}, 64'(r.cyc), 64'(ecyc));
    end
  endtask

  task automatic pop_rsp(input string tag, input int ecyc, output int got_cyc);
    resp_t r;
    got_cyc = -1;
    if (rsp_q.size() == 0) begin
      check({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      r = rsp_q.pop_front();
      got_cyc = r.cyc;
      check({tag, "_rdata"}, 64'(r.data), 64'd0);
      if (ecyc >= 0) check({tag, "_cyc"}, 64'(r.cyc), 64'(ecyc));
    end
  endtask

  int c0, c1, c2, cs, dummy, acc_base, first_pop;
  logic [31:0] pat [4];

  initial begin
    pat[0] = 32'h0123_4567; pat[1] = 32'h89AB_CDEF;
    pat[2] = 32'hCAFE_F00D; pat[3] = 32'h0BAD_C0DE;
    bus.agu_cmd_valid    = 1'b0;
    bus.agu_cmd_read     = 1'b0;
    bus.agu_cmd_addr     = '0;
    bus.agu_cmd_itag     = '0;
    bus.agu_cmd_wdata    = '0;
    bus.agu_cmd_wmask    = '0;
    bus.agu_rsp_ready    = 1'b1;
    bus.lsu_wbck_o_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.agu_cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(bus.agu_rsp_valid), 64'd0);
    check("rst_wb_valid", 64'(bus.lsu_wbck_o_valid), 64'd0);
    check("rst_idle", 64'(lsu_idle), 64'd1);
    check("rst_ram_cs", 64'(ram_cs), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_wem", 64'(ram_wem), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load to the same word
    issue(1'b0, 16'h0010, 1'b0, 32'hDEAD_BEEF, 4'hF, c0);
    issue(1'b1, 16'h0010, 1'b1, 32'h0, 4'h0, c1);
    wait_cyc(6);
    pop_rsp("t1_store", c0 + 2, dummy);
    pop_wb("t1_load", 32'hDEAD_BEEF, 1'b1, c0 + 3);

    // Partial store merges into a preloaded word
    issue(1'b0, 16'h0020, 1'b0, 32'h1122_3344, 4'hF, dummy);
    issue(1'b0, 16'h0020, 1'b0, 32'h0000_AA00, 4'b0010, dummy);
    issue(1'b1, 16'h0020, 1'b0, 32'h0, 4'h0, c0);
    wait_cyc(6);
    pop_rsp("t2_store_a", -1, dummy);
    pop_rsp("t2_store_b", -1, dummy);
    pop_wb("t2_load", 32'h1122_AA44, 1'b0, c0 + 2);

    // Back-to-back loads at full rate
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(4*i), 1'b0, pat[i], 4'hF, dummy);
    wait_cyc(6);
    for (int i = 0; i < 4; i++) pop_rsp("t3_fill", -1, dummy);
    issue(1'b1, 16'h0000, 1'b0, 32'h0, 4'h0, c0);
    for (int i = 1; i < 4; i++) issue(1'b1, 16'(4*i), 1'(i), 32'h0, 4'h0, dummy);
    wait_cyc(6);
    for (int i = 0; i < 4; i++) pop_wb("t3_b2b", pat[i], 1'(i), c0 + 2 + i);

    // Backpressure: credits run out after DEPTH commands
    bus.lsu_wbck_o_ready = 1'b0;
    acc_base = acc_count;
    for (int i = 0; i < 4; i++) issue(1'b1, 16'(4*i), 1'(i), 32'h0, 4'h0, dummy);
    bus.agu_cmd_valid = 1'b1;
    bus.agu_cmd_read  = 1'b1;
    bus.agu_cmd_addr  = 16'h0010;
    bus.agu_cmd_itag  = 1'b0;
    wait_cyc(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_cmd_ready", 64'(bus.agu_cmd_ready), 64'd0);
      check("t4_idle", 64'(lsu_idle), 64'd0);
      check("t4_wb_valid", 64'(bus.lsu_wbck_o_valid), 64'd1);
      check("t4_hold_data", 64'(bus.lsu_wbck_o_data), 64'(pat[0]));
      @(posedge clk); #1;
    end
    check("t4_accepted", 64'(acc_count - acc_base), 64'd4);
    bus.lsu_wbck_o_ready = 1'b1;
    issue(1'b1, 16'h0010, 1'b0, 32'h0, 4'h0, c1);
    issue(1'b1, 16'h0020, 1'b1, 32'h0, 4'h0, dummy);
    wait_cyc(8);
    first_pop = (wb_q.size() > 0) ? wb_q[0].cyc : -100;
    check("t4_ready_after_pop", 64'(c1), 64'(first_pop + 1));
    for (int i = 0; i < 4; i++) pop_wb("t4_drain", pat[i], 1'(i), -1);
    pop_wb("t4_late_a", 32'hDEAD_BEEF, 1'b0, -1);
    pop_wb("t4_late_b", 32'h1122_AA44, 1'b1, -1);

    // Mixed ordering: a stalled store response blocks the following load
    bus.agu_rsp_ready = 1'b0;
    issue(1'b1, 16'h0000, 1'b1, 32'h0, 4'h0, dummy);
    issue(1'b0, 16'h0030, 1'b0, 32'h55AA_55AA, 4'hF, dummy);
    issue(1'b1, 16'h0030, 1'b0, 32'h0, 4'h0, dummy);
    wait_cyc(6);
    @(negedge clk);
    check("t5_wb_blocked", 64'(bus.lsu_wbck_o_valid), 64'd0);
    check("t5_rsp_valid", 64'(bus.agu_rsp_valid), 64'd1);
    check("t5_wb_count", 64'(wb_q.size()), 64'd1);
    @(posedge clk); #1;
    bus.agu_rsp_ready = 1'b1;
    wait_cyc(4);
    pop_wb("t5_load_a", pat[0], 1'b1, -1);
    pop_rsp("t5_store_b", -1, cs);
    pop_wb("t5_load_c", 32'h55AA_55AA, 1'b0, cs + 1);

    // Reset with responses buffered
    bus.lsu_wbck_o_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, 16'(4*i), 1'b0, 32'h0, 4'h0, dummy);
    wait_cyc(3);
    @(negedge clk);
    check("t6_pre_idle", 64'(lsu_idle), 64'd0);
    check("t6_pre_wb_valid", 64'(bus.lsu_wbck_o_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", 64'(bus.agu_cmd_ready), 64'd1);
    check("t6_wb_valid", 64'(bus.lsu_wbck_o_valid), 64'd0);
    check("t6_rsp_valid", 64'(bus.agu_rsp_valid), 64'd0);
    check("t6_idle", 64'(lsu_idle), 64'd1);
    @(posedge clk); #1;
    bus.lsu_wbck_o_ready = 1'b1;
    wait_cyc(6);
    check("t6_no_stale", 64'(wb_q.size()), 64'd0);
    issue(1'b1, 16'h0030, 1'b1, 32'h0, 4'h0, c2);
    wait_cyc(4);
    pop_wb("t6_after_rst", 32'h55AA_55AA, 1'b1, c2 + 2);
    check("t6_final_idle", 64'(lsu_idle), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
